// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for the eight-digit seven-segment scanner.
//               Holds the digit count, the all-segments-off pattern, the
//               hex-to-segment table (active-low, bit 0 = a ... bit 6 = g)
//               and a helper that finds the most significant nonzero nibble.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned IDX_W      = 3;

   // All seven segments off (active-low).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low patterns, g at bit 6, a at bit 0.
   localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
      7'h40,   // 0
      7'h79,   // 1
      7'h24,   // 2
      7'h30,   // 3
      7'h19,   // 4
      7'h12,   // 5
      7'h02,   // 6
      7'h78,   // 7
      7'h00,   // 8
      7'h10,   // 9
      7'h08,   // A
      7'h03,   // b
      7'h46,   // C
      7'h21,   // d
      7'h06,   // E
      7'h0E    // F
   };

   // Position of the highest nonzero nibble; 0 when the whole value is zero,
   // so digit 0 is never considered a leading zero.
   function automatic logic [IDX_W-1:0] msd_nibble(input logic [4*NUM_DIGITS-1:0] value);
      logic [IDX_W-1:0] msd;
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (value[4*i +: 4] != 4'h0) begin
            msd = IDX_W'(i);
         end
      end
      return msd;
   endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational hex nibble to seven-segment decoder.
// Ports       : hex  [3:0] in  - nibble to display
//               seg7 [6:0] out - active-low segments, bit 0 = a ... bit 6 = g
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg7
);

   always_comb begin
      seg7 = HEX_SEG_TABLE[hex];
   end

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_scan
// Description : Time-multiplexed driver for an eight-digit common-anode
//               seven-segment display. A prescaler sets the dwell time per
//               digit; new values arrive over a valid/ready handshake into a
//               pending buffer and are only committed to the displayed value
//               at a frame boundary, so a frame never mixes two values.
// Parameters  : CLK_DIV     - clk cycles per digit slot (1 .. 2**20)
// Macros      : LEADING_ZERO_BLANK_EN - when defined, digits above the most
//               significant nonzero nibble are blanked (dp unaffected).
// Ports       : clk         in   - clock, rising edge
//               rst         in   - synchronous active-high reset
//               data_in     in   - eight hex nibbles, nibble k -> digit k
//               dp_in       in   - decimal points, bit k -> digit k
//               data_valid  in   - upstream offers data_in/dp_in
//               data_ready  out  - block can accept a new value
//               seg         out  - active-low segments, [6:0] = g..a, [7] = dp
//               an          out  - active-low one-hot digit enables
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan
   import seg_pkg::*;
#(
   parameter int unsigned CLK_DIV = 100000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic [7:0]  seg,
   output logic [7:0]  an
);

   localparam int unsigned PRE_W        = 20;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0] prescale;
   logic [IDX_W-1:0] index;
   logic [31:0]      disp_data;
   logic [7:0]       disp_dp;
   logic [31:0]      pend_data;
   logic [7:0]       pend_dp;
   logic             pending;

   logic             tick;
   logic             frame_end;
   logic             accept;
   logic             commit;
   logic             pending_next;
   logic [3:0]       nibble;
   logic [6:0]       digit_font;
   logic [6:0]       seg_bits;

   assign tick      = (prescale == PRE_MAX);
   assign frame_end = tick && (index == IDX_LAST);
   assign accept    = data_valid && data_ready;
   // data_ready is low whenever pending is set, so an accept and a commit
   // can never coincide; an accept on a boundary waits for the next one.
   assign commit    = frame_end && pending && !accept;
   assign pending_next = accept | (pending & ~frame_end);

   assign nibble = disp_data[{index, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .hex  (nibble),
      .seg7 (digit_font)
   );

   always_comb begin
      seg_bits = digit_font;
`ifdef LEADING_ZERO_BLANK_EN
      if (index > msd_nibble(disp_data)) begin
         seg_bits = SEG_BLANK;
      end
`else
      seg_bits = digit_font;
`endif
   end

   // Scan timing: prescaler and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescale <= '0;
         index    <= '0;
      end else begin
         prescale <= tick ? '0 : prescale + PRE_W'(1);
         if (tick) begin
            index <= index + IDX_W'(1);
         end
      end
   end

   // Handshake, pending buffer and frame-aligned commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         disp_data  <= '0;
         disp_dp    <= '0;
         pending    <= 1'b0;
         data_ready <= 1'b0;
      end else begin
         if (accept) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
         end
         if (commit) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
         end
         pending    <= pending_next;
         data_ready <= ~pending_next;
      end
   end

   // Output registers: one cycle behind the current index.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= 8'hFF;
         an  <= 8'hFF;
      end else begin
         an  <= ~(8'h01 << index);
         seg <= {~disp_dp[index], seg_bits};
      end
   end

endmodule : seg_display_scan
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_scan
// Description : Self-checking bench for seg_display_scan. Two instances run
//               side by side (CLK_DIV=4 and CLK_DIV=1) against a reference
//               model that derives the shown digit from elapsed cycles and
//               tracks the accepted/committed values per instance.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_display_scan;

   localparam int unsigned DIV0 = 4;
   localparam int unsigned DIV1 = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_in = '0;
   logic [7:0]  dp_in = '0;
   logic        valid0 = 1'b0;
   logic        valid1 = 1'b0;
   logic        ready0, ready1;
   logic [7:0]  seg0, an0, seg1, an1;

   always #5 clk = ~clk;

   seg_display_scan #(.CLK_DIV(DIV0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .data_valid (valid0),
      .data_ready (ready0),
      .seg        (seg0),
      .an         (an0)
   );

   seg_display_scan #(.CLK_DIV(DIV1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .data_valid (valid1),
      .data_ready (ready1),
      .seg        (seg1),
      .an         (an1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Lit segments (active-high, g..a) of each hex glyph.
   function automatic logic [6:0] lit(input logic [3:0] h);
      case (h)
         4'h0: lit = 7'h3F;  4'h1: lit = 7'h06;  4'h2: lit = 7'h5B;  4'h3: lit = 7'h4F;
         4'h4: lit = 7'h66;  4'h5: lit = 7'h6D;  4'h6: lit = 7'h7D;  4'h7: lit = 7'h07;
         4'h8: lit = 7'h7F;  4'h9: lit = 7'h6F;  4'hA: lit = 7'h77;  4'hB: lit = 7'h7C;
         4'hC: lit = 7'h39;  4'hD: lit = 7'h5E;  4'hE: lit = 7'h79;  default: lit = 7'h71;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic [7:0] dp, input int digit);
      logic [6:0] s;
      s = ~lit(v[digit*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      begin
         int top;
         top = 0;
         for (int i = 0; i < 8; i++) if (v[i*4 +: 4] != 4'h0) top = i;
         if (digit > top) s = 7'h7F;
      end
`endif
      return {~dp[digit], s};
   endfunction

   // Reference model state per instance.
   int unsigned m_div [2] = '{DIV0, DIV1};
   int unsigned m_k   [2];
   logic        m_rdy [2];
   logic        m_pend[2];
   logic [31:0] m_pval[2];
   logic [7:0]  m_pdp [2];
   logic [31:0] m_disp[2];
   logic [7:0]  m_ddp [2];
   logic [7:0]  e_seg [2];
   logic [7:0]  e_an  [2];

   // Called at each rising edge with the inputs that edge samples.
   task automatic model_edge(input int id, input logic valid);
      int digit;
      if (rst) begin
         m_k[id]    = 0;
         m_rdy[id]  = 1'b0;
         m_pend[id] = 1'b0;
         m_pval[id] = '0;
         m_pdp[id]  = '0;
         m_disp[id] = '0;
         m_ddp[id]  = '0;
         e_seg[id]  = 8'hFF;
         e_an[id]   = 8'hFF;
      end else begin
         m_k[id]++;
         // Output after edge k shows the digit of elapsed cycle k-1.
         digit     = int'(((m_k[id] - 1) / m_div[id]) % 8);
         e_seg[id] = exp_seg(m_disp[id], m_ddp[id], digit);
         e_an[id]  = ~(8'h01 << digit);
         if (valid && m_rdy[id]) begin
            m_pend[id] = 1'b1;
            m_pval[id] = data_in;
            m_pdp[id]  = dp_in;
         end else if ((m_k[id] % (8 * m_div[id])) == 0 && m_pend[id]) begin
            m_disp[id] = m_pval[id];
            m_ddp[id]  = m_pdp[id];
            m_pend[id] = 1'b0;
         end
         m_rdy[id] = !m_pend[id];
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0, valid0);
      model_edge(1, valid1);
      @(negedge clk);
      check_eq("seg0",   {24'h0, seg0}, {24'h0, e_seg[0]});
      check_eq("an0",    {24'h0, an0},  {24'h0, e_an[0]});
      check_eq("ready0", {31'h0, ready0}, {31'h0, m_rdy[0]});
      check_eq("seg1",   {24'h0, seg1}, {24'h0, e_seg[1]});
      check_eq("an1",    {24'h0, an1},  {24'h0, e_an[1]});
      check_eq("ready1", {31'h0, ready1}, {31'h0, m_rdy[1]});
   endtask

   initial begin
      @(negedge clk);
      // Reset held for three cycles.
      rst = 1'b1;
      repeat (3) step();
      check_eq("rst_seg",   {24'h0, seg0}, 32'hFF);
      check_eq("rst_an",    {24'h0, an0},  32'hFF);
      check_eq("rst_ready", {31'h0, ready0}, 32'h0);

      // First cycle after release.
      rst = 1'b0;
      step();
      check_eq("rel_an",    {24'h0, an0},  32'hFE);
      check_eq("rel_seg",   {24'h0, seg0}, 32'hC0);
      check_eq("rel_ready", {31'h0, ready0}, 32'h1);

      // Idle scan.
      repeat (40) step();

      // Single accept mid-frame.
      data_in = 32'h1234ABCD;
      dp_in   = 8'h00;
      valid0  = 1'b1;
      step();
      valid0  = 1'b0;
      check_eq("hs_ready_low", {31'h0, ready0}, 32'h0);
      repeat (70) step();

      // Back-pressure: valid held with changing data.
      valid0 = 1'b1;
      repeat (80) begin
         data_in = $urandom;
         dp_in   = 8'($urandom);
         step();
      end
      valid0 = 1'b0;

      // Decimal point on digit 0 with the fast-scanning instance.
      data_in = 32'h0;
      dp_in   = 8'h01;
      valid1  = 1'b1;
      step();
      valid1  = 1'b0;
      repeat (24) step();

      // Leading-zero pattern.
      data_in = 32'h0000_00A0;
      dp_in   = 8'h00;
      valid0  = 1'b1;
      valid1  = 1'b1;
      step();
      valid0  = 1'b0;
      valid1  = 1'b0;
      repeat (70) step();

      // Randomized traffic.
      repeat (400) begin
         data_in = $urandom;
         dp_in   = 8'($urandom);
         valid0  = ($urandom_range(0, 3) == 0);
         valid1  = ($urandom_range(0, 2) == 0);
         step();
      end
      valid0 = 1'b0;
      valid1 = 1'b0;

      // Reset mid-operation discards a pending value.
      repeat (10) step();
      data_in = 32'hFEDC_BA98;
      dp_in   = 8'hFF;
      valid0  = 1'b1;
      valid1  = 1'b1;
      step();
      valid0  = 1'b0;
      valid1  = 1'b0;
      rst     = 1'b1;
      repeat (2) step();
      rst     = 1'b0;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seg_display_scan
`default_nettype wire

// File: doc/seg_display_scan.md
SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 100000, meaning clk cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL provide port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port data_in  input  32  eight hex nibbles; nibble k drives digit k (digit 0 = rightmost).
REQ-005 SHALL provide port dp_in  input  8  decimal-point enables, bit k for digit k; captured with data_in.
REQ-006 SHALL provide port data_valid  input  1  upstream datapath offers data_in/dp_in.
REQ-007 SHALL provide port data_ready  output  1  block can accept a new value.
REQ-008 SHALL provide port seg  output  8  active-low segments; bits 0..6 = a..g, bit 7 = dp.
REQ-009 SHALL provide port an  output  8  active-low digit enables, one-hot-low.

Function
REQ-010 SHALL run a prescaler counting 0..CLK_DIV-1, asserting an internal tick when count = CLK_DIV-1, then wrapping to 0; CLK_DIV=1 ticks every cycle.
REQ-011 SHALL hold a 3-bit digit index advancing by 1 on each tick, wrapping 7->0; frame boundary = tick while index = 7.
REQ-012 SHALL accept data_in/dp_in into a pending buffer on any cycle where data_valid && data_ready, setting pending=1.
REQ-013 SHALL drive data_ready = !pending (registered); data_ready deasserts the cycle after an accept.
REQ-014 SHALL copy the pending buffer into the display register at a frame boundary when pending=1, clearing pending; data_ready reasserts the following cycle.
REQ-015 SHALL never update the display register mid-frame (no tearing); a frame boundary with pending=0 leaves it unchanged.
REQ-016 SHALL treat an accept and a frame boundary in the same cycle as: accept only (pending was 0), commit at the next boundary.
REQ-017 SHALL register seg and an every cycle: an = ~(1<<index), seg = decode(nibble[index]) with bit 7 = ~dp[index]; latency from index change to outputs is 1 cycle.
REQ-018 SHALL decode hex 0..F to standard 7-segment patterns (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110, active-low, g at bit 6).

Reset
REQ-019 SHALL, while rst=1, set prescaler=0, index=0, display register=0, dp register=0, pending=0, seg=8'hFF, an=8'hFF, data_ready=0.
REQ-020 SHALL, in the first cycle after rst falls, drive data_ready=1, an=8'hFE, seg=8'hC0.
REQ-021 SHALL discard any pending value on reset asserted mid-operation; no accept occurs in a reset cycle.

Configuration
REQ-022 SHALL, with LEADING_ZERO_BLANK_EN defined, blank (segments a..g = 1) every digit above the most significant nonzero nibble of the display register; digit 0 never blanked; dp still follows dp register.
REQ-023 SHALL, without LEADING_ZERO_BLANK_EN, show all eight digits including leading zeros.

Structure
REQ-024 SHALL place in package seg_pkg: NUM_DIGITS=8, SEG_BLANK=7'h7F, the 16-entry hex-to-segment constant table.
REQ-025 SHALL instantiate one combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out) for the decode.

Verification (CLK_DIV=4 unless stated)
REQ-026 SHALL verify reset: hold rst 3 cycles -> seg=8'hFF, an=8'hFF, data_ready=0; release -> next cycle an=8'hFE, seg=8'hC0, data_ready=1.
REQ-027 SHALL verify scan: no loads -> an steps FE,FD,FB,...,7F,FE with each value held exactly 4 cycles.
REQ-028 SHALL verify handshake: data_in=32'h1234ABCD, data_valid 1 cycle mid-frame -> data_ready low next cycle; digits keep 0 until frame boundary; next frame digit 0 seg=8'hA1 (d), digit 7 seg=8'hF9 (1); data_ready high cycle after commit.
REQ-029 SHALL verify back-pressure: data_valid held high with changing data while data_ready=0 -> only the first value is displayed; second value accepted after reassertion.
REQ-030 SHALL verify dp and CLK_DIV=1: dp_in=8'h01, data_in=0 -> digit 0 seg=8'h40, others 8'hC0; an changes every cycle.
REQ-031 SHALL verify LEADING_ZERO_BLANK_EN: data_in=32'h0000_00A0 -> digits 7..2 seg=8'hFF, digit 1 seg=8'h88, digit 0 seg=8'hC0; without macro digits 7..2 = 8'hC0.
